// File: rtl/shift_pkg.sv
// Shared definitions for the iterative right shifter: widths, FSM states
// and fill-mode constants.
package shift_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int STAGE_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

endpackage : shift_pkg

// File: rtl/shift_right_stage.sv
// One power-of-two right-shift stage: shifts by 2^k with zero or sign fill.
// Purely combinational; the top module reuses it on every iteration.
module shift_right_stage
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0]   acc_i,
    input  logic [STAGE_W-1:0] k_i,
    input  logic               mode_i,
    output logic [WIDTH-1:0]   acc_o
);

    logic fill;

    // The sign comes from the current accumulator, so an arithmetic shift
    // keeps propagating the original sign stage after stage.
    assign fill = (mode_i == SHIFT_ARITH) & acc_i[WIDTH-1];

    // NOTE: every path assigns acc_o (default arm included), so no latch is inferred.
    always_comb begin
        case (k_i)
            3'd0:    acc_o = {{1{fill}},  acc_i[WIDTH-1:1]};
            3'd1:    acc_o = {{2{fill}},  acc_i[WIDTH-1:2]};
            3'd2:    acc_o = {{4{fill}},  acc_i[WIDTH-1:4]};
            3'd3:    acc_o = {{8{fill}},  acc_i[WIDTH-1:8]};
            3'd4:    acc_o = {{16{fill}}, acc_i[WIDTH-1:16]};
            default: acc_o = acc_i;
        endcase
    end

endmodule : shift_right_stage

// File: rtl/seq_shift_right.sv
// Multi-cycle 32-bit logical/arithmetic right shifter with start/done
// handshake; applies one power-of-two stage per clock, largest stage first.
module seq_shift_right
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   I,
    output logic [WIDTH-1:0]   R,
    output logic               busy,
    output logic               done
);

    state_e               state_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     acc_d;
    logic [SHAMT_W-1:0]   rem_q;
    logic [SHAMT_W-1:0]   rem_d;
    logic                 mode_q;
    logic [WIDTH-1:0]     r_q;
    logic                 busy_q;
    logic                 done_q;
    logic [STAGE_W-1:0]   k;

    // Highest set bit of the remaining amount; the last match in the loop wins.
    always_comb begin
        k = '0;
        for (int b = 0; b < SHAMT_W; b++) begin
            if (rem_q[b]) begin
                k = STAGE_W'(b);
            end
        end
        rem_d    = rem_q;
        rem_d[k] = 1'b0;
    end

    shift_right_stage u_stage (
        .acc_i  (acc_q),
        .k_i    (k),
        .mode_i (mode_q),
        .acc_o  (acc_d)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            mode_q  <= SHIFT_LOGICAL;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= I;
                        rem_q   <= shamt;
                        mode_q  <= arith;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rem_q == '0) begin
                        r_q     <= acc_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign R    = r_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : seq_shift_right

// File: tb/tb_seq_shift_right.sv
// Self-checking bench for seq_shift_right: directed cases plus random
// operations compared against a plain-arithmetic shift model.
`timescale 1ns/1ps
module tb_seq_shift_right;

    logic        clk;
    logic        reset;
    logic        start;
    logic        arith;
    logic [4:0]  shamt;
    logic [31:0] I;
    logic [31:0] R;
    logic        busy;
    logic        done;

    int          vectors;
    int          miscompares;
    logic [31:0] model_r;
    logic [31:0] exp_r;
    int          exp_lat;

    seq_shift_right dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .arith (arith),
        .shamt (shamt),
        .I     (I),
        .R     (R),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] sh,
                                              input logic a);
        logic signed [31:0] s;
        s = v;
        if (a) return 32'(s >>> sh);
        return v >> sh;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present an operation for one start edge, then scramble the inputs.
    task automatic launch(input logic [31:0] v, input logic [4:0] sh, input logic a);
        I       = v;
        shamt   = sh;
        arith   = a;
        start   = 1'b1;
        exp_r   = ref_shift(v, sh, a);
        exp_lat = $countones(sh) + 1;
        @(posedge clk); #1;
        start = 1'b0;
        I     = $urandom;
        shamt = 5'($urandom);
        arith = 1'($urandom);
    endtask

    // Follow the in-flight operation to its done edge; optionally poke a
    // start while busy, which must be ignored.
    task automatic finish_op(input bit poke);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            check("busy_inflight", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            check("r_hold", R, model_r);
            if (poke && n == 0) begin
                start = 1'b1;
                I     = 32'h1;
                shamt = 5'd0;
                arith = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (done) got = 1'b1;
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("result", R, exp_r);
        check("busy_at_done", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        model_r = exp_r;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_r", R, model_r);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_r     = '0;
        reset       = 1'b0;
        start       = 1'b0;
        arith       = 1'b0;
        shamt       = '0;
        I           = '0;

        #2 reset = 1'b1;
        #2;
        check("reset_r", R, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle_cycle();

        launch(32'h8000_0000, 5'd4, 1'b0);
        finish_op(1'b0);
        check("t1_value", R, 32'h0800_0000);
        idle_cycle();

        launch(32'h8000_0000, 5'd4, 1'b1);
        finish_op(1'b0);
        check("t2_value", R, 32'hF800_0000);
        idle_cycle();

        launch(32'h8000_0000, 5'd31, 1'b1);
        finish_op(1'b0);
        check("t3_arith", R, 32'hFFFF_FFFF);
        idle_cycle();
        launch(32'h8000_0000, 5'd31, 1'b0);
        finish_op(1'b0);
        check("t3_logical", R, 32'h0000_0001);
        idle_cycle();

        launch(32'h1234_5678, 5'd0, 1'b1);
        finish_op(1'b0);
        check("t4_zero_shift", R, 32'h1234_5678);
        idle_cycle();

        // Ignored start while busy, then a back-to-back start in the done cycle.
        launch(32'hF000_0000, 5'd8, 1'b0);
        finish_op(1'b1);
        check("t5_ignored_start", R, 32'h00F0_0000);
        launch(32'hA5A5_A5A5, 5'd3, 1'b1);
        finish_op(1'b0);
        check("t5_back_to_back", R, 32'hF4B4_B4B4);
        idle_cycle();

        // Abort mid-operation: immediate reset state and no late done pulse.
        launch(32'h8765_4321, 5'd31, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        check("abort_r", R, 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        model_r = '0;
        repeat (8) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle_busy", 32'(busy), 32'd0);
        end
        launch(32'h0000_0100, 5'd8, 1'b0);
        finish_op(1'b0);
        check("t6_fresh_op", R, 32'h0000_0001);
        idle_cycle();

        for (int t = 0; t < 40; t++) begin
            launch($urandom, 5'($urandom), 1'($urandom));
            finish_op(1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_seq_shift_right

// File: doc/seq_shift_right.md
Name: seq_shift_right

Overview:
- Multi-cycle 32-bit right shifter for the Mini-MIPS ALU path. Executes srl/srlv (logical) and sra/srav (arithmetic).
- Mirror of the combinational left barrel shifter, but iterative: applies one power-of-two stage per clock.
- Uses a start/done handshake and holds its result until the next accepted operation.
- Sits beside the ALU; the control unit stalls on busy.

Parameters:
- WIDTH, 32, data width (only 32 supported).
- SHAMT_W, 5, shift-amount width = log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk edge
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured with start
- shamt  input  5  shift amount 0..31; captured with start
- I  input  32  operand; captured with start
- R  output  32  result; registered, holds last result
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when R is updated

Behaviour:
- Reset state (asynchronous, active-high): state=IDLE, R=0, busy=0, done=0, internal acc=0, rem=0, fill mode=0.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 at an edge: acc<=I, rem<=shamt, mode<=arith, busy<=1, done<=0, go to SHIFT.
  - Otherwise stay in IDLE; done<=0.
- SHIFT, each edge:
  - rem==0: R<=acc, done<=1, busy<=0, go to IDLE.
  - Else: k = index of highest set bit of rem; acc<=acc>>(2^k) with fill; clear bit k of rem.
- Fill rule: vacated MSBs take acc[31] if mode=1, else 0. The sign bit is taken from the current acc, which keeps the original sign under arithmetic mode.
- Latency: start edge to done edge = popcount(shamt)+1 edges.
  - shamt=0: 1 edge.
  - shamt=31: 6 edges.
  - Maximum is 6.
- Start while busy=1: ignored. No queuing and no effect on the in-flight operation. Inputs need only be valid on the start edge.
- Back-to-back: start may be asserted in the same cycle done=1. That start is accepted because state is IDLE there; the next operation begins and R keeps its value until its own done.
- R changes only on the done edge (or reset). Never exposes partial results.
- Reset mid-operation: abort immediately, return to reset state, no done pulse.
- shamt values are always in range (5-bit). No wrap or error case.

Decomposition:
- Shared package shift_pkg:
  - WIDTH=32, SHAMT_W=5
  - State encoding for IDLE/SHIFT
  - Mode constants SHIFT_LOGICAL=0, SHIFT_ARITH=1
- Sub-module shift_right_stage (combinational):
  - Inputs: acc, stage index k (0..4), mode.
  - Output: acc shifted right by 2^k with the correct fill, built as a 5-way select.
  - Instantiated once.
- Highest-set-bit priority logic stays inline in the top module.

Test Plan:
1. I=0x80000000, shamt=4, arith=0, start pulse -> done exactly 2 edges after the start edge, R=0x08000000; busy high for those 2 cycles only.
2. Same operand, arith=1 -> R=0xF8000000, same latency.
3. I=0x80000000, shamt=31:
   - arith=1 -> R=0xFFFFFFFF, done 6 edges after start.
   - arith=0 -> R=0x00000001.
4. I=0x12345678, shamt=0 -> done 1 edge after start, R=0x12345678.
5. Launch I=0xF0000000, shamt=8, arith=0. Then:
   - Assert start with I=0x1, shamt=0 while busy -> ignored; R=0x00F00000 at done.
   - Issue a new start in the done cycle -> accepted; next R reflects the new operands.
6. Launch shamt=31. Assert reset on cycle 3 -> R=0, busy=0, done=0 immediately, with no done pulse afterward. A fresh op (I=0x00000100, shamt=8, arith=0) then yields R=0x00000001.
